alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU.
- Generalises width to WIDTH, widens the opcode to 3 bits (8 ops), and adds signed-overflow and negative flags.
- Rotate-left takes a variable shift amount and executes one bit per cycle.
- Sits between the controller and the register file; valid/ready handshake on both input and output sides.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4, power of 2).
- SHW, $clog2(WIDTH), width of the rotate-amount field (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active low
- ALUinA  in  WIDTH  operand A
- ALUinB  in  WIDTH  operand B
- InsSel  in  3  opcode
- ShAmt  in  SHW  rotate amount (ROL only)
- InValid  in  1  operands/opcode valid
- InReady  out  1  block can accept a command
- ALUout  out  WIDTH  registered result
- CO  out  1  carry/borrow/rotate-out
- Z  out  1  result == 0
- N  out  1  result MSB
- OV  out  1  signed overflow
- OutValid  out  1  result and flags valid
- OutReady  in  1  consumer accepts result

Behaviour:
- Clock and reset: one clock (clk). rst_n is synchronous and active-low.
- Reset (rst_n low at a clk edge):
  - state=IDLE; ALUout, CO, Z, N, OV and OutValid all 0.
  - InReady=0 while rst_n is low; InReady=1 from the first cycle after release.
- Opcodes (result R):
  - 000 AND
  - 001 XOR
  - 010 ADD A+B
  - 011 ROL A by ShAmt
  - 100 SUB A-B
  - 101 OR
  - 110 PASSB
  - 111 NOT A
- Flags:
  - ADD: CO = carry out; OV = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
  - SUB: CO = borrow (1 iff A<B unsigned); OV = (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
  - ROL: CO = last bit rotated out (= R[0]); ShAmt=0 gives CO=0.
  - All other ops: CO=0.
  - OV=0 for all ops except ADD and SUB.
  - Z = (R==0) and N = R[WIDTH-1] for every op.
- FSM states:
  - IDLE: InReady=1. A handshake (InValid && InReady) latches A, B, InsSel, ShAmt.
    - Non-ROL op, or ROL with ShAmt=0 → DONE. Result registered at this edge.
    - ROL with ShAmt>0 → EXEC, with count=ShAmt and the working register loaded with A.
  - EXEC: InReady=0. Working register rotates left 1 bit per cycle and count decrements.
    - When count reaches 1, that edge writes the final R and flags, and the FSM goes to DONE.
  - DONE: OutValid=1, InReady=0.
    - ALUout and all flags are held stable until OutReady=1.
    - On OutReady → IDLE; OutValid falls on the next cycle.
- Latency (accept edge to OutValid high):
  - 1 cycle for non-ROL ops and ROL with ShAmt=0.
  - ShAmt+1 cycles for ROL with ShAmt>0.
- Throughput: one command in flight. No accept while in EXEC or DONE; InValid there is ignored and not queued.
- Input stability: operands need only be valid on the accept edge; later changes have no effect.
- Output hold: ALUout and flags keep their last values after OutValid drops, until the next result is written.
- Reset mid-EXEC or mid-DONE: operation discarded, no OutValid pulse, normal reset values.
- Wrap-around: rotate amount is modulo WIDTH by construction (SHW bits). Arithmetic wraps mod 2^WIDTH.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_AND … OP_NOT);
  - state encoding (ST_IDLE, ST_EXEC, ST_DONE);
  - a flags struct/bundle {CO, Z, N, OV}.
- Natural sub-module: alu_core. It is combinational, WIDTH-parametrised, and computes R plus flags for the single-cycle ops.
- alu_seq owns the FSM, the rotate counter/working register, and the output registers.

Test Plan (WIDTH=8):
1. AND A=0x61 B=0x95 → one cycle after accept: OutValid=1, ALUout=0x01, Z=0, CO=0, N=0, OV=0.
2. ADD A=0x61 B=0x67 → ALUout=0xC8, CO=0, OV=1, N=1, Z=0. Then SUB A=0x10 B=0x20 → 0xF0, CO=1, OV=0, N=1.
3. XOR A=0x29 B=0x29 → ALUout=0x00, Z=1. NOT A=0xFF → 0x00, Z=1.
4. ROL A=0xC9 ShAmt=1 → 0x93, CO=1, latency 2. ROL A=0xC9 ShAmt=3 → 0x4E, CO=0, latency 4. Check InReady=0 throughout EXEC.
5. Backpressure: ADD result with OutReady=0 for 5 cycles and InValid=1 with new operands → ALUout/flags unchanged and no new accept. OutReady=1 → IDLE; the new command is accepted the following cycle.
6. Reset mid-op: ROL 0xC9 ShAmt=7, rst_n low for 1 cycle at 3rd EXEC cycle → OutValid never asserts, ALUout=0. InReady=1 on the cycle after release; the next AND completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM encoding, flag bundle.
package alu_pkg;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_XOR   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_ROL   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_PASSB = 3'b110;
  localparam logic [2:0] OP_NOT   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic co;
    logic z;
    logic n;
    logic ov;
  } alu_flags_t;

  function automatic alu_flags_t make_flags(input logic co, input logic z,
                                            input logic n, input logic ov);
    alu_flags_t f;
    f.co = co;
    f.z  = z;
    f.n  = n;
    f.ov = ov;
    return f;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational datapath for the single-cycle ops. ROL here is a rotate by
// zero (result = A, CO = 0); non-zero rotates are iterated in alu_seq.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] r_o,
  output alu_flags_t       flags_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           co;
  logic           ov;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  // Select the result and the op-specific carry/overflow.
  always_comb begin
    r_o = '0;
    co  = 1'b0;
    ov  = 1'b0;
    case (op_i)
      OP_AND:   r_o = a_i & b_i;
      OP_XOR:   r_o = a_i ^ b_i;
      OP_ADD: begin
        r_o = sum[WIDTH-1:0];
        co  = sum[WIDTH];
        ov  = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_ROL:   r_o = a_i;
      OP_SUB: begin
        r_o = diff[WIDTH-1:0];
        co  = diff[WIDTH];
        ov  = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_OR:    r_o = a_i | b_i;
      OP_PASSB: r_o = b_i;
      OP_NOT:   r_o = ~a_i;
      default:  r_o = '0;
    endcase
  end

  assign flags_o = make_flags(co, (r_o == '0), r_o[WIDTH-1], ov);

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes; rotate-left runs one bit per cycle.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready for a command; accept latches operands
//   ST_EXEC | ROL in progress, count_q rotations still to do
//   ST_DONE | result/flags valid and held until the consumer takes them
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ALUinA,
  input  logic [WIDTH-1:0] ALUinB,
  input  logic [2:0]       InsSel,
  input  logic [SHW-1:0]   ShAmt,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] ALUout,
  output logic             CO,
  output logic             Z,
  output logic             N,
  output logic             OV,
  output logic             OutValid,
  input  logic             OutReady
);

  alu_state_e       state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  alu_flags_t       flags_q;
  logic [WIDTH-1:0] work_q;
  logic [SHW-1:0]   count_q;

  logic [WIDTH-1:0] core_r;
  alu_flags_t       core_flags;
  logic [WIDTH-1:0] work_rot;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i     (ALUinA),
    .b_i     (ALUinB),
    .op_i    (InsSel),
    .r_o     (core_r),
    .flags_o (core_flags)
  );

  assign work_rot = {work_q[WIDTH-2:0], work_q[WIDTH-1]};

  // FSM, rotate counter/working register and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      work_q      <= '0;
      count_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (InValid && in_ready_q) begin
            in_ready_q <= 1'b0;
            if ((InsSel == OP_ROL) && (ShAmt != '0)) begin
              work_q  <= ALUinA;
              count_q <= ShAmt;
              state_q <= ST_EXEC;
            end else begin
              result_q    <= core_r;
              flags_q     <= core_flags;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_EXEC: begin
          work_q  <= work_rot;
          count_q <= count_q - SHW'(1);
          if (count_q == SHW'(1)) begin
            // The bit just rotated out lands in R[0], so CO mirrors it.
            result_q    <= work_rot;
            flags_q     <= make_flags(work_rot[0], (work_rot == '0),
                                      work_rot[WIDTH-1], 1'b0);
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (OutReady) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign InReady  = in_ready_q;
  assign OutValid = out_valid_q;
  assign ALUout   = result_q;
  assign CO       = flags_q.co;
  assign Z        = flags_q.z;
  assign N        = flags_q.n;
  assign OV       = flags_q.ov;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8) with hand-computed expected values.
module tb_alu_seq;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_XOR   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_ROL   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_PASSB = 3'b110;
  localparam logic [2:0] OP_NOT   = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ALUinA, ALUinB;
  logic [2:0] InsSel;
  logic [2:0] ShAmt;
  logic       InValid;
  logic       InReady;
  logic [7:0] ALUout;
  logic       CO, Z, N, OV;
  logic       OutValid;
  logic       OutReady;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ALUinA   (ALUinA),
    .ALUinB   (ALUinB),
    .InsSel   (InsSel),
    .ShAmt    (ShAmt),
    .InValid  (InValid),
    .InReady  (InReady),
    .ALUout   (ALUout),
    .CO       (CO),
    .Z        (Z),
    .N        (N),
    .OV       (OV),
    .OutValid (OutValid),
    .OutReady (OutReady)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; all driving and sampling happens 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] sh, input logic [7:0] er,
                         input logic eco, input logic ez, input logic en, input logic eov,
                         input int elat);
    int guard = 0;
    int lat;
    while (!InReady && guard < 20) begin
      tick();
      guard++;
    end
    check({tag, "_inready"}, InReady, 1);
    ALUinA = a; ALUinB = b; InsSel = op; ShAmt = sh; InValid = 1'b1;
    tick();
    // Scramble inputs after the accept edge; they must have no effect.
    InValid = 1'b0; ALUinA = ~a; ALUinB = ~b; InsSel = ~op; ShAmt = ~sh;
    lat = 1;
    while (!OutValid && lat < 40) begin
      check({tag, "_busy_inready"}, InReady, 0);
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, elat);
    check({tag, "_outvalid"}, OutValid, 1);
    check({tag, "_done_inready"}, InReady, 0);
    check({tag, "_aluout"}, ALUout, er);
    check({tag, "_flags"}, {CO, Z, N, OV}, {eco, ez, en, eov});
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    check({tag, "_outvalid_drop"}, OutValid, 0);
    check({tag, "_hold"}, ALUout, er);
  endtask

  initial begin
    int guard;
    int seen_valid;
    rst_n = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    ALUinA = '0; ALUinB = '0; InsSel = '0; ShAmt = '0;
    tick(); tick();
    check("rst_aluout", ALUout, 0);
    check("rst_flags", {CO, Z, N, OV}, 4'b0000);
    check("rst_outvalid", OutValid, 0);
    check("rst_inready", InReady, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_inready", InReady, 1);

    //      tag        op        A      B      sh    R      CO    Z     N     OV   lat
    run_cmd("and",    OP_AND,   8'h61, 8'h95, 3'd0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    run_cmd("add_ov", OP_ADD,   8'h61, 8'h67, 3'd0, 8'hC8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    run_cmd("sub_bw", OP_SUB,   8'h10, 8'h20, 3'd0, 8'hF0, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    run_cmd("xor_z",  OP_XOR,   8'h29, 8'h29, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    run_cmd("not_z",  OP_NOT,   8'hFF, 8'h00, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    run_cmd("add_co", OP_ADD,   8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    run_cmd("sub_ov", OP_SUB,   8'h80, 8'h01, 3'd0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    run_cmd("or",     OP_OR,    8'h0C, 8'h30, 3'd0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    run_cmd("passb",  OP_PASSB, 8'h12, 8'h80, 3'd0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    run_cmd("rol0",   OP_ROL,   8'hC9, 8'h00, 3'd0, 8'hC9, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    run_cmd("rol1",   OP_ROL,   8'hC9, 8'h00, 3'd1, 8'h93, 1'b1, 1'b0, 1'b1, 1'b0, 2);
    run_cmd("rol3",   OP_ROL,   8'hC9, 8'h00, 3'd3, 8'h4E, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    run_cmd("rol7",   OP_ROL,   8'h01, 8'h00, 3'd7, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 8);

    // Backpressure: result held, new command not accepted while in DONE.
    ALUinA = 8'h61; ALUinB = 8'h67; InsSel = OP_ADD; ShAmt = '0; InValid = 1'b1;
    tick();
    check("bp_outvalid", OutValid, 1);
    ALUinA = 8'h61; ALUinB = 8'h95; InsSel = OP_AND;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_aluout", ALUout, 8'hC8);
      check("bp_hold_flags", {CO, Z, N, OV}, 4'b0011);
      check("bp_hold_valid", OutValid, 1);
      check("bp_no_accept", InReady, 0);
    end
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    check("bp_release_valid", OutValid, 0);
    check("bp_release_inready", InReady, 1);
    check("bp_release_hold", ALUout, 8'hC8);
    tick();
    InValid = 1'b0;
    check("bp_new_valid", OutValid, 1);
    check("bp_new_aluout", ALUout, 8'h01);
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;

    // Reset in the middle of a long rotate.
    ALUinA = 8'hC9; InsSel = OP_ROL; ShAmt = 3'd7; InValid = 1'b1;
    tick();
    InValid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_aluout", ALUout, 0);
    check("mid_rst_outvalid", OutValid, 0);
    check("mid_rst_inready", InReady, 0);
    tick();
    check("mid_rst_inready_after", InReady, 1);
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      if (OutValid) seen_valid++;
      tick();
    end
    check("mid_rst_no_pulse", seen_valid, 0);
    run_cmd("and_after_rst", OP_AND, 8'hF0, 8'h3C, 3'd0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
